// File: rtl/morse_player.sv
// Morse playback engine: walks NUM_SYM latched symbol slots, plays each
// enabled symbol unit by unit with silent gaps between symbols, and gates a
// square-wave buzzer tone with the unit envelope. Optional repeat looping.
module morse_player #(
    parameter int UNIT_DIV  = 50_000_000,
    parameter int TONE_DIV  = 25_000,
    parameter int NUM_SYM   = 7,
    parameter int SYM_BITS  = 14,
    parameter int LEN_W     = 4,
    parameter int GAP_UNITS = 3
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              start,
    input  logic                                              stop,
    input  logic                                              repeat_en,
    input  logic [NUM_SYM*SYM_BITS-1:0]                       code,
    input  logic [NUM_SYM*LEN_W-1:0]                          len,
    input  logic [NUM_SYM-1:0]                                sym_en,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              env,
    output logic                                              tone,
    output logic [((NUM_SYM > 1) ? $clog2(NUM_SYM) : 1)-1:0]  sym_idx
);

    localparam int SIDX_W = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
    // Slot index needs one extra value: NUM_SYM marks "pass finished".
    localparam int IDX_W  = $clog2(NUM_SYM + 1);
    localparam int DIV_W  = $clog2(UNIT_DIV);
    localparam int MAXU   = (SYM_BITS > GAP_UNITS) ? SYM_BITS : GAP_UNITS;
    localparam int UNIT_W = $clog2(MAXU + 1);
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_PICK, S_GAP, S_PLAY, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [DIV_W-1:0]            div_q, div_d;
    logic [UNIT_W-1:0]           unit_q, unit_d;
    logic                        played_q, played_d;   // something played this pass
    logic                        gap_q, gap_d;         // something played since start
    logic [NUM_SYM*SYM_BITS-1:0] code_q, code_d;
    logic [NUM_SYM*LEN_W-1:0]    len_q, len_d;
    logic [NUM_SYM-1:0]          en_q, en_d;
    logic [TONE_W-1:0]           tcnt_q, tcnt_d;
    logic                        tlow_q, tlow_d;       // 0 = high half of tone period

    int                          sel;
    int                          eff_len;
    logic [SYM_BITS-1:0]         cur_code;
    logic [LEN_W-1:0]            cur_len;
    logic                        playable;
    logic                        last_unit;
    logic                        unit_end;
    logic                        end_pass;

    // Decode the currently selected shadow slot: bits, clipped length, playability.
    always_comb begin
        sel       = (idx_q < IDX_W'(NUM_SYM)) ? int'(idx_q) : 0;
        cur_code  = SYM_BITS'(code_q >> (sel * SYM_BITS));
        cur_len   = LEN_W'(len_q >> (sel * LEN_W));
        eff_len   = (int'(cur_len) > SYM_BITS) ? SYM_BITS : int'(cur_len);
        playable  = (|(en_q & (NUM_SYM'(1) << sel))) && (cur_len != '0);
        last_unit = (int'(unit_q) == eff_len - 1);
        unit_end  = (div_q == DIV_W'(UNIT_DIV - 1));
        end_pass  = (idx_q == IDX_W'(NUM_SYM)) ||
                    (!playable && (idx_q == IDX_W'(NUM_SYM - 1)));
        env       = (state_q == S_PLAY) && (|(cur_code & (SYM_BITS'(1) << unit_q)));
        tone      = env && !tlow_q;
        busy      = (state_q != S_IDLE);
        sym_idx   = idx_q[SIDX_W-1:0];
    end

    // Next-state logic for the playback FSM, unit timing and tone divider.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        div_d    = div_q;
        unit_d   = unit_q;
        played_d = played_q;
        gap_d    = gap_q;
        code_d   = code_q;
        len_d    = len_q;
        en_d     = en_q;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    code_d   = code;
                    len_d    = len;
                    en_d     = sym_en;
                    idx_d    = '0;
                    div_d    = '0;
                    unit_d   = '0;
                    played_d = 1'b0;
                    gap_d    = 1'b0;
                    state_d  = S_PICK;
                end
            end
            S_PICK: begin
                if (end_pass) begin
                    if (repeat_en && played_q) begin
                        idx_d    = '0;
                        played_d = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (playable) begin
                    div_d   = '0;
                    unit_d  = '0;
                    state_d = (gap_q && (GAP_UNITS > 0)) ? S_GAP : S_PLAY;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_GAP: begin
                if (unit_end) begin
                    div_d = '0;
                    if (unit_q == UNIT_W'(GAP_UNITS - 1)) begin
                        unit_d  = '0;
                        state_d = S_PLAY;
                    end else begin
                        unit_d = unit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_PLAY: begin
                if (unit_end) begin
                    div_d = '0;
                    if (last_unit) begin
                        unit_d   = '0;
                        played_d = 1'b1;
                        gap_d    = 1'b1;
                        idx_d    = idx_q + 1'b1;
                        state_d  = S_PICK;
                    end else begin
                        unit_d = unit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort from any active state; start in IDLE already loses to stop above.
        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        // Tone restarts on its high half whenever the envelope is off.
        if (!env) begin
            tcnt_d = '0;
            tlow_d = 1'b0;
        end else if (tcnt_q == TONE_W'(TONE_DIV - 1)) begin
            tcnt_d = '0;
            tlow_d = !tlow_q;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
            tlow_d = tlow_q;
        end
    end

    // State, counters and shadow copies of the message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            div_q    <= '0;
            unit_q   <= '0;
            played_q <= 1'b0;
            gap_q    <= 1'b0;
            code_q   <= '0;
            len_q    <= '0;
            en_q     <= '0;
            tcnt_q   <= '0;
            tlow_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            div_q    <= div_d;
            unit_q   <= unit_d;
            played_q <= played_d;
            gap_q    <= gap_d;
            code_q   <= code_d;
            len_q    <= len_d;
            en_q     <= en_d;
            tcnt_q   <= tcnt_d;
            tlow_q   <= tlow_d;
        end
    end

endmodule

// File: tb/tb_morse_player.sv
// Directed bench for morse_player with small timing parameters.
module tb_morse_player;

    localparam int UNIT_DIV  = 4;
    localparam int TONE_DIV  = 2;
    localparam int NUM_SYM   = 3;
    localparam int SYM_BITS  = 4;
    localparam int LEN_W     = 3;
    localparam int GAP_UNITS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        repeat_en;
    logic [11:0] code;
    logic [8:0]  len;
    logic [2:0]  sym_en;
    logic        busy;
    logic        done;
    logic        env;
    logic        tone;
    logic [1:0]  sym_idx;

    int nvec = 0;
    int nerr = 0;

    morse_player #(
        .UNIT_DIV (UNIT_DIV),
        .TONE_DIV (TONE_DIV),
        .NUM_SYM  (NUM_SYM),
        .SYM_BITS (SYM_BITS),
        .LEN_W    (LEN_W),
        .GAP_UNITS(GAP_UNITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .repeat_en(repeat_en),
        .code     (code),
        .len      (len),
        .sym_en   (sym_en),
        .busy     (busy),
        .done     (done),
        .env      (env),
        .tone     (tone),
        .sym_idx  (sym_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_r(input int c, input int a, input int b);
        return (c >= a) && (c <= b);
    endfunction

    // Cycle c counts from the edge that samples start (cycle 0 = start driven).
    function automatic bit exp_env(input int cs, input int c);
        case (cs)
            1, 7: return in_r(c, 2, 5) || in_r(c, 10, 13);
            2:    return in_r(c, 2, 5) || in_r(c, 16, 23);
            4:    return in_r(c, 2, 17);
            5:    return in_r(c, 2, 5) || in_r(c, 10, 13) ||
                         in_r(c, 25, 28) || in_r(c, 33, 36);
            6:    return in_r(c, 2, 3);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int done_cyc(input int cs);
        case (cs)
            1, 7: return 16;
            2:    return 25;
            3:    return 4;
            4:    return 20;
            5:    return 39;
            default: return -1;
        endcase
    endfunction

    function automatic int last_busy(input int cs);
        case (cs)
            6:       return 3;
            8:       return 0;
            default: return done_cyc(cs);
        endcase
    endfunction

    function automatic int exp_idx(input int cs, input int c);
        case (cs)
            1, 7: case (c) 1: return 0; 14: return 1; 15: return 2; default: return -1; endcase
            2:    case (c) 1: return 0; 6: return 1; 7: return 2; 16: return 2; default: return -1; endcase
            3:    case (c) 1: return 0; 2: return 1; 3: return 2; default: return -1; endcase
            4:    case (c) 18: return 1; 19: return 2; default: return -1; endcase
            5:    case (c) 14: return 1; 16: return 0; 38: return 2; default: return -1; endcase
            default: return -1;
        endcase
    endfunction

    task automatic load(input logic [11:0] c, input logic [8:0] l, input logic [2:0] e, input logic r);
        code      = c;
        len       = l;
        sym_en    = e;
        repeat_en = r;
    endtask

    // Called at a negedge with the DUT idle; that cycle is cycle 0.
    task automatic run_case(input int cs, input int ncyc);
        bit e, pe, t;
        int rs;
        pe    = 1'b0;
        rs    = 0;
        start = 1'b1;
        if (cs == 8) stop = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                stop  = 1'b0;
            end
            e = exp_env(cs, c);
            if (e && !pe) rs = c;
            t  = e && (((c - rs) % (2 * TONE_DIV)) < TONE_DIV);
            pe = e;
            chk($sformatf("case%0d env cyc%0d", cs, c), 32'(env), 32'(e));
            chk($sformatf("case%0d tone cyc%0d", cs, c), 32'(tone), 32'(t));
            chk($sformatf("case%0d done cyc%0d", cs, c), 32'(done), 32'(c == done_cyc(cs)));
            chk($sformatf("case%0d busy cyc%0d", cs, c), 32'(busy), 32'(in_r(c, 1, last_busy(cs))));
            if (exp_idx(cs, c) >= 0)
                chk($sformatf("case%0d sym_idx cyc%0d", cs, c), 32'(sym_idx), 32'(exp_idx(cs, c)));
            if (cs == 5 && c == 30) repeat_en = 1'b0;
            if (cs == 6 && c == 3)  stop = 1'b1;
            if (cs == 6 && c == 5)  stop = 1'b0;
            if (cs == 7 && c == 4) begin
                start  = 1'b1;
                code   = 12'hFFF;
                len    = {3'd4, 3'd4, 3'd4};
                sym_en = 3'b111;
            end
            if (cs == 7 && c == 6) start = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        load(12'h0, 9'h0, 3'b000, 1'b0);
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset env", 32'(env), 32'd0);
        chk("reset tone", 32'(tone), 32'd0);
        chk("reset sym_idx", 32'(sym_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single symbol 0101, three units
        load({4'h0, 4'h0, 4'b0101}, {3'd0, 3'd0, 3'd3}, 3'b001, 1'b0);
        run_case(1, 18);
        // 2: slots 0 and 2, slot 1 disabled with live-looking data
        load({4'b0011, 4'b1111, 4'b0001}, {3'd2, 3'd4, 3'd1}, 3'b101, 1'b0);
        run_case(2, 27);
        // 3: nothing enabled, repeat on
        load({4'hF, 4'hF, 4'hF}, {3'd4, 3'd4, 3'd4}, 3'b000, 1'b1);
        run_case(3, 6);
        // 4: length clipped to SYM_BITS
        load({4'h0, 4'h0, 4'b1111}, {3'd0, 3'd0, 3'd7}, 3'b001, 1'b0);
        run_case(4, 22);
        // 5: repeat loop, repeat dropped during the second pass
        load({4'h0, 4'h0, 4'b0101}, {3'd0, 3'd0, 3'd3}, 3'b001, 1'b1);
        run_case(5, 42);
        // 6: stop in the middle of the first unit
        load({4'h0, 4'h0, 4'b0101}, {3'd0, 3'd0, 3'd3}, 3'b001, 1'b0);
        run_case(6, 10);
        // 7: start and new input data while busy are ignored
        load({4'h0, 4'h0, 4'b0101}, {3'd0, 3'd0, 3'd3}, 3'b001, 1'b0);
        run_case(7, 18);
        // 8: stop wins over start in IDLE
        load({4'h0, 4'h0, 4'b0101}, {3'd0, 3'd0, 3'd3}, 3'b001, 1'b0);
        run_case(8, 3);

        // Asynchronous reset in the middle of a tone-on unit
        load({4'h0, 4'h0, 4'b1111}, {3'd0, 3'd0, 3'd4}, 3'b001, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-reset env", 32'(env), 32'd1);
        chk("pre-reset busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset env", 32'(env), 32'd0);
        chk("async reset tone", 32'(tone), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset done", 32'(done), 32'd0);
        chk("async reset sym_idx", 32'(sym_idx), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset busy", 32'(busy), 32'd0);
        chk("post-reset env", 32'(env), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
